// File: rtl/ex_pipe_regs_pkg.sv
// Shared definitions for the EX-stage pipeline registers: ALU control field
// layout, lane-width codes, function codes and the register-file address width.
package ex_pipe_regs_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam int OPCODE_W   = 6;
  localparam int WW_W       = 2;
  localparam int FUNC_W     = 6;
  localparam int ALU_CTRL_W = OPCODE_W + WW_W + FUNC_W;

  localparam int FUNC_LSB   = 0;
  localparam int WW_LSB     = FUNC_LSB + FUNC_W;
  localparam int OPCODE_LSB = WW_LSB + WW_W;

  localparam logic [OPCODE_W-1:0] OP_VALU = 6'b101010;

  typedef enum logic [WW_W-1:0] {
    WW_8  = 2'b00,
    WW_16 = 2'b01,
    WW_32 = 2'b10,
    WW_64 = 2'b11
  } ww_e;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_VAND  = 6'b000000,
    FUNC_VOR   = 6'b000001,
    FUNC_VXOR  = 6'b000010,
    FUNC_VNOT  = 6'b000011,
    FUNC_VMOV  = 6'b000100,
    FUNC_VADD  = 6'b000101,
    FUNC_VSUB  = 6'b000110,
    FUNC_VMULE = 6'b000111,
    FUNC_VMULO = 6'b001000,
    FUNC_VSLL  = 6'b001001,
    FUNC_VSRL  = 6'b001010,
    FUNC_VSRA  = 6'b001011,
    FUNC_VRTTH = 6'b001100,
    FUNC_VDIV  = 6'b001101,
    FUNC_VMOD  = 6'b001110,
    FUNC_VSQRT = 6'b001111
  } func_e;

  function automatic logic [ALU_CTRL_W-1:0] pack_alu_ctrl(
    input logic [OPCODE_W-1:0] opcode,
    input ww_e                 ww,
    input func_e               func
  );
    return {opcode, ww, func};
  endfunction

endpackage

// File: rtl/ex_pipe_regs_fwd_mux.sv
// Three-way operand selector: youngest producer (EX) first, then EX/WB,
// then the register-file read data.
module ex_pipe_regs_fwd_mux #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      ex_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_data,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic [DATA_WIDTH-1:0]     operand
);

  always_comb begin
    // NOTE: default first so every path assigns operand and no latch is inferred.
    operand = rf_data;
    if (ex_wen && (ex_addr == src_addr)) begin
      operand = ex_data;
    end else if (wb_wen && (wb_addr == src_addr)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/ex_pipe_regs.sv
// ID/EX and EX/WB pipeline registers around the vector ALU, with operand
// forwarding at capture time, stall (hold + bubble) and flush.
module ex_pipe_regs
  import ex_pipe_regs_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = ex_pipe_regs_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_vld,
  output logic                      id_ready,
  input  logic [DATA_WIDTH-1:0]     id_ra_data,
  input  logic [DATA_WIDTH-1:0]     id_rb_data,
  input  logic [REG_ADDR_WIDTH-1:0] id_ra_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rb_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [ALU_CTRL_W-1:0]     id_alu_ctrl,
  input  logic                      id_regwrite,
  input  logic [4:0]                id_imme,
  input  logic                      ex_stall,
  input  logic                      ex_flush,
  output logic [DATA_WIDTH-1:0]     ex_ra,
  output logic [DATA_WIDTH-1:0]     ex_rb,
  output logic [ALU_CTRL_W-1:0]     ex_alu_ctrl,
  output logic                      ex2alu_regwrite,
  output logic [4:0]                alu_imme,
  output logic                      ex_vld,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic [DATA_WIDTH-1:0]     alu_out,
  input  logic                      alu2wb_regwirte,
  output logic                      wb_regwrite,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  output logic [DATA_WIDTH-1:0]     wb_data
);

  logic [DATA_WIDTH-1:0]     ex_ra_q, ex_ra_d, ex_rb_q, ex_rb_d;
  logic [ALU_CTRL_W-1:0]     ex_alu_ctrl_q, ex_alu_ctrl_d;
  logic                      ex_regwrite_q, ex_regwrite_d;
  logic [4:0]                alu_imme_q, alu_imme_d;
  logic                      ex_vld_q, ex_vld_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_q, ex_rd_addr_d;
  logic                      wb_regwrite_q, wb_regwrite_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0]     fwd_ra, fwd_rb;

  ex_pipe_regs_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .src_addr (id_ra_addr),
    .rf_data  (id_ra_data),
    .ex_wen   (alu2wb_regwirte),
    .ex_addr  (ex_rd_addr_q),
    .ex_data  (alu_out),
    .wb_wen   (wb_regwrite_q),
    .wb_addr  (wb_rd_addr_q),
    .wb_data  (wb_data_q),
    .operand  (fwd_ra)
  );

  ex_pipe_regs_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .src_addr (id_rb_addr),
    .rf_data  (id_rb_data),
    .ex_wen   (alu2wb_regwirte),
    .ex_addr  (ex_rd_addr_q),
    .ex_data  (alu_out),
    .wb_wen   (wb_regwrite_q),
    .wb_addr  (wb_rd_addr_q),
    .wb_data  (wb_data_q),
    .operand  (fwd_rb)
  );

  always_comb begin
    ex_ra_d       = ex_ra_q;
    ex_rb_d       = ex_rb_q;
    ex_alu_ctrl_d = ex_alu_ctrl_q;
    ex_regwrite_d = ex_regwrite_q;
    alu_imme_d    = alu_imme_q;
    ex_vld_d      = ex_vld_q;
    ex_rd_addr_d  = ex_rd_addr_q;
    wb_regwrite_d = 1'b0;
    wb_rd_addr_d  = wb_rd_addr_q;
    wb_data_d     = wb_data_q;
    // A stalled instruction keeps its operands and re-executes; its result is
    // committed only once the stall releases.
    if (!ex_stall) begin
      ex_vld_d      = id_vld & ~ex_flush;
      ex_regwrite_d = id_regwrite & id_vld & ~ex_flush;
      ex_ra_d       = fwd_ra;
      ex_rb_d       = fwd_rb;
      ex_alu_ctrl_d = id_alu_ctrl;
      alu_imme_d    = id_imme;
      ex_rd_addr_d  = id_rd_addr;
      wb_regwrite_d = alu2wb_regwirte;
      wb_rd_addr_d  = ex_rd_addr_q;
      wb_data_d     = alu_out;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ra_q       <= '0;
      ex_rb_q       <= '0;
      ex_alu_ctrl_q <= '0;
      ex_regwrite_q <= 1'b0;
      alu_imme_q    <= '0;
      ex_vld_q      <= 1'b0;
      ex_rd_addr_q  <= '0;
      wb_regwrite_q <= 1'b0;
      wb_rd_addr_q  <= '0;
      wb_data_q     <= '0;
    end else begin
      ex_ra_q       <= ex_ra_d;
      ex_rb_q       <= ex_rb_d;
      ex_alu_ctrl_q <= ex_alu_ctrl_d;
      ex_regwrite_q <= ex_regwrite_d;
      alu_imme_q    <= alu_imme_d;
      ex_vld_q      <= ex_vld_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_addr_q  <= wb_rd_addr_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign id_ready        = ~ex_stall;
  assign ex_ra           = ex_ra_q;
  assign ex_rb           = ex_rb_q;
  assign ex_alu_ctrl     = ex_alu_ctrl_q;
  assign ex2alu_regwrite = ex_regwrite_q;
  assign alu_imme        = alu_imme_q;
  assign ex_vld          = ex_vld_q;
  assign ex_rd_addr      = ex_rd_addr_q;
  assign wb_regwrite     = wb_regwrite_q;
  assign wb_rd_addr      = wb_rd_addr_q;
  assign wb_data         = wb_data_q;

endmodule

// File: doc/ex_pipe_regs.md
Name: ex_pipe_regs

Overview:
- Pipeline-register block wrapped around the vector ALU.
- Upstream, it captures decoded operands and control from the ID stage into the ID/EX register, which drives the ALU inputs.
- Downstream, it captures the ALU result into the EX/WB register, which drives the register-file write port.
- It resolves RAW hazards by forwarding from the ALU output and from the EX/WB register at capture time, and it supports stall and flush.

Parameters:
DATA_WIDTH, 64, operand/result width
REG_ADDR_WIDTH, 5, register-file address width (32 registers)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
id_vld  in  1  decode presents a valid instruction
id_ready  out  1  block accepts from decode this cycle; equals ~ex_stall
id_ra_data  in  DATA_WIDTH  RF read data, port A
id_rb_data  in  DATA_WIDTH  RF read data, port B
id_ra_addr  in  REG_ADDR_WIDTH  source A register number
id_rb_addr  in  REG_ADDR_WIDTH  source B register number
id_rd_addr  in  REG_ADDR_WIDTH  destination register number
id_alu_ctrl  in  14  {opcode[6], ww[2], func[6]}
id_regwrite  in  1  instruction writes rd
id_imme  in  5  shift immediate
ex_stall  in  1  hold ID/EX; bubble into EX/WB
ex_flush  in  1  discard the instruction entering ID/EX
ex_ra  out  DATA_WIDTH  ALU operand A
ex_rb  out  DATA_WIDTH  ALU operand B
ex_alu_ctrl  out  14  ALU control
ex2alu_regwrite  out  1  ID/EX regwrite AND ID/EX valid
alu_imme  out  5  ALU immediate
ex_vld  out  1  ID/EX holds a live instruction
ex_rd_addr  out  REG_ADDR_WIDTH  ID/EX destination (for hazard unit)
alu_out  in  DATA_WIDTH  ALU result (combinational)
alu2wb_regwirte  in  1  ALU write-enable (already func/ww-qualified)
wb_regwrite  out  1  RF write enable
wb_rd_addr  out  REG_ADDR_WIDTH  RF write address
wb_data  out  DATA_WIDTH  RF write data

Behaviour:
- Reset, asynchronous, active-high: every register and output clears to 0.
  - ex_vld=0, ex2alu_regwrite=0, wb_regwrite=0; all data, control and address outputs 0.
  - id_ready follows ~ex_stall combinationally.
- ID/EX update, on each clk rising edge with ex_stall=0:
  - Load decode fields.
  - ex_vld <= id_vld & ~ex_flush.
  - If the loaded valid bit is 0, the regwrite bit is stored 0; data fields load regardless.
- ID/EX with ex_stall=1: all fields hold.
  - Decode must hold its instruction, since id_ready=0.
  - ex_flush is ignored while stalled.
- Operand forwarding, evaluated for A and B independently at capture:
  1. If alu2wb_regwirte=1 and ex_rd_addr == src addr, use alu_out (the youngest producer).
  2. Else if wb_regwrite=1 and wb_rd_addr == src addr, use wb_data.
  3. Else use RF read data.
  - Register 0 is an ordinary register: no special case, it forwards like any other.
  - Forwarding is applied only on capture; held operands are not re-forwarded. They were already correct at capture.
- EX/WB update:
  - ex_stall=0: wb_regwrite <= alu2wb_regwirte, wb_data <= alu_out, wb_rd_addr <= ex_rd_addr.
  - ex_stall=1: wb_regwrite <= 0; wb_data and wb_rd_addr hold. The stalled instruction re-executes and commits exactly once, after the stall releases.
- ex_flush never affects the instruction already in ID/EX or EX/WB.
- Latency: an accepted instruction appears on the ALU inputs 1 cycle after acceptance; its result is on the wb_* outputs 1 cycle later.
- Throughput: 1 instruction per cycle when unstalled.
- Simultaneous events: stall beats flush; forward source 1 beats source 2; reset beats everything.
- Reset mid-stall: the pipeline empties and no write is issued.

Decomposition:
- Shared package: ALU control field widths and offsets (opcode 6, ww 2, func 6); ww codes (8/16/32/64-bit lanes); func code constants 000000..001111; REG_ADDR_WIDTH.
- One sub-module, fwd_mux: combinational 3-way operand selector (src addr, RF data, EX match/data, WB match/data), instantiated twice.

Test Plan:
1. Basic flow: decode vadd ww=11, ra=5, rb=3, rd=R4, regwrite=1 -> ex_ra=5, ex_rb=3 next cycle; wb_regwrite=1, wb_rd_addr=4, wb_data=8 the following cycle.
2. EX forward: back-to-back, instr1 writes R4=8, instr2 reads R4 with RF data 0 -> instr2 captures ex_ra=8.
3. WB forward with both sources matching: R4 in EX/WB=8 and in EX=0x10 -> ex_ra=0x10; with only the WB match -> ex_ra=8.
4. Stall, 2 cycles with instr in EX: id_ready=0, ID/EX holds, wb_regwrite=0 both cycles; after release, exactly one write of the correct value.
5. Flush vs stall: flush=1 with stall=0 -> ex_vld=0, ex2alu_regwrite=0, no write 2 cycles later; flush=1 with stall=1 -> ID/EX unchanged.
6. Reset asserted mid-stream, asynchronously off clock edge -> all outputs 0 immediately, no wb_regwrite pulse after deassert.
